alu_div_unit: RTL and testbench
===============================

// Module: alu_div_unit
// PURPOSE
//  Iterative radix-2 restoring divider next to the ALU. It takes the ALU operands
//  (scrA dividend, scrB divisor) when the decoder issues alucontrol 4'b1010 (div).
//  It returns quotient/remainder to the EX-stage result mux after WIDTH cycles.
//  A start/busy/done handshake replaces the single-cycle combinational divide.
// PARAMETERS
//  WIDTH  32  operand, quotient and remainder width in bits; WIDTH >= 4.
// PORTS
//  clk        in   1      rising-edge clock; the only clock
//  resetn     in   1      asynchronous reset, active-low
//  start      in   1      request; sampled only when busy=0
//  signed_op  in   1      1: two's-complement div; 0: unsigned divu
//  scrA       in   WIDTH  dividend; captured on the accepting edge
//  scrB       in   WIDTH  divisor; captured on the accepting edge
//  busy       out  1      1 while iterating (state CALC)
//  done       out  1      one-cycle pulse; results valid from this cycle on
//  quotient   out  WIDTH  registered quotient
//  remainder  out  WIDTH  registered remainder
//  divzero    out  1      1 with done when the captured divisor was 0
// BEHAVIOUR
//  - Reset (resetn=0, async): state=IDLE. busy, done, divzero=0. quotient, remainder,
//    count and operand registers all =0.
//  - States: IDLE -> CALC on an accepted start. CALC -> DONE after WIDTH iterations.
//    DONE -> IDLE next edge, or DONE -> CALC if start=1 in DONE (back-to-back).
//  - Accept: start=1 and busy=0 at edge N. Operands are captured as magnitudes.
//    Result signs are latched: quotient sign = sA^sB; remainder sign = sA.
//  - CALC: one bit per edge, MSB first. rem = {rem,dividend_msb} - divisor when the
//    result is non-negative. 6-bit counter runs 0..WIDTH-1.
//  - Latency: done=1 from edge N+WIDTH to edge N+WIDTH+1. busy=1 from edge N to edge
//    N+WIDTH. Sign correction is applied combinationally on the last iteration.
//  - start while busy=1 is ignored: no queuing, no error.
//  - Divide by zero: CALC is skipped; DONE is entered at edge N+1.
//    quotient={WIDTH{1'b1}}, remainder=scrA as captured, divzero=1.
//  - Signed overflow (-2^(WIDTH-1) / -1): quotient=0x8000_0000, remainder=0.
//    This is the natural wrap; no flag is raised.
//  - Remainder takes the dividend's sign and |remainder| < |divisor|.
//  - quotient, remainder and divzero hold until the next accept.
//    On the next accept, divzero clears to 0.
//  - Reset mid-CALC aborts immediately and returns to the reset values.
//    No done pulse is generated.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined:
//    - If |scrA| < |scrB| at accept (divisor nonzero), CALC is skipped.
//    - DONE is entered at edge N+1 with quotient=0 and remainder=scrA.
//    - busy stays 0.
//  DIV_EARLY_OUT_EN undefined:
//    - Every non-zero divide takes exactly WIDTH cycles.
//  Divide-by-zero fast path exists in both builds.
// STRUCTURE
//  alu_pkg (shared):
//    - ALU control codes: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010,
//      ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_DIV=4'b1010.
//    - Divider state encoding: DIV_IDLE=2'd0, DIV_CALC=2'd1, DIV_DONE=2'd2.
//  Sub-module div_step:
//    - Combinational single iteration: (rem_in, dvd_bit, divisor) -> (rem_out, q_bit).
//    - Instantiated once inside alu_div_unit.
//  FSM, counter, sign handling and output registers live in alu_div_unit.
// TESTING
//  1. Unsigned, scrA=100, scrB=25, start at edge N -> done at N+32.
//     quotient=4, remainder=0, divzero=0; busy high for edges N..N+31.
//  2. Div by zero, scrA=100, scrB=0 -> done at N+1.
//     quotient=32'hFFFF_FFFF, remainder=100, divzero=1.
//  3. Signed, scrA=-7 (32'hFFFF_FFF9), scrB=2 -> done at N+32.
//     quotient=32'hFFFF_FFFD (-3), remainder=32'hFFFF_FFFF (-1).
//  4. Start held high through CALC with different operands -> ignored.
//     A single done; results match the first operands.
//  5. resetn pulled low at N+10 -> busy, done, quotient and remainder are 0 at once.
//     No done pulse. A fresh start after release completes correctly.
//  6. scrA=5, scrB=10, unsigned, DIV_EARLY_OUT_EN defined -> done at N+1,
//     quotient=0, remainder=5.
//     Same stimulus without the macro -> done at N+32, same values.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes and the divider state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_DIV = 4'b1010;

  localparam int unsigned DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/alu_div_unit_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem_in,
  input  logic             i_dvd_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem_out,
  output logic             o_q_bit
);

  logic [WIDTH+1:0] w_diff;

  // Two guard bits: the shifted partial remainder can reach 2*divisor-1.
  always_comb begin
    w_diff    = {1'b0, i_rem_in, i_dvd_bit} - {2'b00, i_divisor};
    o_q_bit   = ~w_diff[WIDTH+1];
    o_rem_out = o_q_bit ? w_diff[WIDTH-1:0] : {i_rem_in[WIDTH-2:0], i_dvd_bit};
  end

endmodule

// File: rtl/alu_div_unit.sv
// Iterative radix-2 restoring divider with start/busy/done handshake.
// Optional build macro DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module alu_div_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] scrA,
  input  logic [WIDTH-1:0] scrB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divzero
);

  localparam logic [DIV_CNT_W-1:0] LAST = DIV_CNT_W'(WIDTH - 1);

  div_state_e r_state;
  div_state_e w_next;

  logic [DIV_CNT_W-1:0] r_count;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_dvd;
  logic [WIDTH-1:0]     r_dvs;
  logic                 r_qneg;
  logic                 r_rneg;
  logic                 r_dz;
  logic                 r_fast;

  logic             w_accept;
  logic             w_last;
  logic             w_early;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_rem_out;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_quo_mag;
  logic [WIDTH-1:0] w_rem_mag;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem_in  (r_rem),
    .i_dvd_bit (r_dvd[WIDTH-1]),
    .i_divisor (r_dvs),
    .o_rem_out (w_rem_out),
    .o_q_bit   (w_q_bit)
  );

  always_comb begin
    w_accept = start && ((r_state == DIV_IDLE) || (r_state == DIV_DONE));
    w_last   = (r_count == LAST);
    w_a_mag  = (signed_op && scrA[WIDTH-1]) ? -scrA : scrA;
    w_b_mag  = (signed_op && scrB[WIDTH-1]) ? -scrB : scrB;
`ifdef DIV_EARLY_OUT_EN
    w_early  = (w_b_mag != '0) && (w_a_mag < w_b_mag);
`else
    w_early  = 1'b0;
`endif
  end

  // Fast paths park the dividend magnitude in r_dvd so the remainder equals the captured scrA.
  always_comb begin
    w_quo_mag = r_fast ? '0 : {r_dvd[WIDTH-2:0], w_q_bit};
    w_rem_mag = r_fast ? r_dvd : w_rem_out;
    w_quo_fix = r_qneg ? -w_quo_mag : w_quo_mag;
    w_rem_fix = r_rneg ? -w_rem_mag : w_rem_mag;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DIV_IDLE: if (w_accept) w_next = DIV_CALC;
      DIV_CALC: if (r_fast || w_last) w_next = DIV_DONE;
      DIV_DONE: w_next = w_accept ? DIV_CALC : DIV_IDLE;
      default:  w_next = DIV_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == DIV_CALC) && !r_fast;
    done = (r_state == DIV_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count   <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_dz      <= 1'b0;
      r_fast    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      divzero   <= 1'b0;
    end else if (w_accept) begin
      r_count <= '0;
      r_rem   <= '0;
      r_dvd   <= w_a_mag;
      r_dvs   <= w_b_mag;
      r_qneg  <= signed_op && (scrA[WIDTH-1] ^ scrB[WIDTH-1]);
      r_rneg  <= signed_op && scrA[WIDTH-1];
      r_dz    <= (scrB == '0);
      r_fast  <= (scrB == '0) || w_early;
      divzero <= 1'b0;
    end else if (r_state == DIV_CALC) begin
      if (r_fast) begin
        quotient  <= r_dz ? '1 : w_quo_fix;
        remainder <= w_rem_fix;
        divzero   <= r_dz;
      end else begin
        r_rem   <= w_rem_out;
        r_dvd   <= {r_dvd[WIDTH-2:0], w_q_bit};
        r_count <= r_count + DIV_CNT_W'(1);
        if (w_last) begin
          quotient  <= w_quo_fix;
          remainder <= w_rem_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_div_unit.sv
// Scoreboard bench for alu_div_unit: directed divides, latency, handshake and reset abort.
module tb_alu_div_unit;

  localparam int EO_LAT =
`ifdef DIV_EARLY_OUT_EN
    1;
`else
    32;
`endif

  logic        clk;
  logic        resetn;
  logic        start;
  logic        signed_op;
  logic [31:0] scrA;
  logic [31:0] scrB;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        divzero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
    int          issue;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;
  int   cyc;

  alu_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .signed_op (signed_op),
    .scrA      (scrA),
    .scrB      (scrB),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .divzero   (divzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_quotient"}, quotient, e.q);
        chk({e.tag, "_remainder"}, remainder, e.r);
        chk({e.tag, "_divzero"}, {31'd0, divzero}, {31'd0, e.dz});
        chk({e.tag, "_latency"}, 32'(cyc - e.issue), 32'(e.lat));
      end
    end
  end

  task automatic issue(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz,
                       input int elat, input logic push);
    exp_t e;
    @(negedge clk);
    signed_op = s;
    scrA      = a;
    scrB      = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      e.q = eq; e.r = er; e.dz = edz; e.lat = elat; e.issue = cyc; e.tag = tag;
      sb.push_back(e);
    end
    start = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", tag, sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    resetn = 1'b0; start = 1'b0; signed_op = 1'b0; scrA = '0; scrB = '0;
    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_divzero", {31'd0, divzero}, 32'd0);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Unsigned 100/25 with busy window checks.
    issue("udiv100_25", 1'b0, 32'd100, 32'd25, 32'd4, 32'd0, 1'b0, 32, 1'b1);
    chk("t1_busy_at_N", {31'd0, busy}, 32'd1);
    repeat (31) @(posedge clk);
    #1;
    chk("t1_busy_at_N31", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    chk("t1_busy_at_N32", {31'd0, busy}, 32'd0);
    chk("t1_done_at_N32", {31'd0, done}, 32'd1);
    wait_drain("t1");

    issue("divzero", 1'b0, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 1'b1, 1, 1'b1);
    wait_drain("t2");
    issue("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32, 1'b1);
    wait_drain("t3");

    // Start held high through CALC with other operands must be ignored.
    issue("held_start", 1'b0, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 32, 1'b1);
    start = 1'b1; scrA = 32'd50; scrB = 32'd5;
    repeat (20) @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain("t4");

    // Reset mid-calculation.
    issue("aborted", 1'b0, 32'd100, 32'd25, 32'd0, 32'd0, 1'b0, 0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("t5_busy_before_reset", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("t5_busy_reset", {31'd0, busy}, 32'd0);
    chk("t5_done_reset", {31'd0, done}, 32'd0);
    chk("t5_quotient_reset", quotient, 32'd0);
    chk("t5_remainder_reset", remainder, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    issue("after_reset", 1'b0, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 32, 1'b1);
    wait_drain("t5");

    issue("early_out_u", 1'b0, 32'd5, 32'd10, 32'd0, 32'd5, 1'b0, EO_LAT, 1'b1);
    wait_drain("t6");
    issue("early_out_s", 1'b1, 32'hFFFF_FFFD, 32'd7, 32'd0, 32'hFFFF_FFFD, 1'b0, EO_LAT, 1'b1);
    wait_drain("t6s");

    issue("s_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 32, 1'b1);
    wait_drain("ovf");
    issue("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 32, 1'b1);
    wait_drain("s2");
    issue("sdiv_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 32, 1'b1);
    wait_drain("s3");
    issue("udiv_max_16", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 32, 1'b1);
    wait_drain("u2");
    issue("sdivzero_neg", 1'b1, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1, 1, 1'b1);
    wait_drain("dz2");

    // Back-to-back: new start accepted in the DONE cycle.
    issue("b2b_first", 1'b0, 32'd100, 32'd25, 32'd4, 32'd0, 1'b0, 32, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    chk("b2b_done_seen", {31'd0, done}, 32'd1);
    signed_op = 1'b0; scrA = 32'd200; scrB = 32'd9; start = 1'b1;
    @(posedge clk);
    #1;
    begin
      exp_t e;
      e.q = 32'd22; e.r = 32'd2; e.dz = 1'b0; e.lat = 32; e.issue = cyc; e.tag = "b2b_second";
      sb.push_back(e);
    end
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_drain("b2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
